// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte requesters onto one UART TX serializer; round robin when
// UART_TX_ARB_RR_EN is defined, fixed lowest-index priority otherwise.
// Latency: request sampled in IDLE at edge N -> gnt/tx_data_valid high in cycle N+1.
// Backpressure: no arbitration while tx_busy is high; one grant per frame, the
// next grant comes only after tx_busy has risen and fallen again.
module uart_tx_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  tx_busy,
    output logic [NREQ-1:0]       gnt,
    output logic                  tx_data_valid,
    output logic [WIDTH-1:0]      tx_p_data,
    output logic [1:0]            active_id,
    output logic                  arb_busy
);

    // Sparse encoding so that any corrupted value is distinguishable and
    // falls into the recovery branch of the state machine.
    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        ISSUE      = 3'b001,
        WAIT_START = 3'b010,
        WAIT_DONE  = 3'b100
    } state_t;

    state_t     state;
    logic       win_vld;
    logic [1:0] win_id;

`ifdef UART_TX_ARB_RR_EN
    // Index of the most recently granted requester; search begins one past it.
    logic [1:0] rr_ptr;

    // Round-robin winner: walk from rr_ptr+1 around the ring, first set bit wins.
    // Walking downward leaves the closest candidate as the final assignment.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_id  = 2'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end
`else
    // Fixed-priority winner: lowest requesting index wins.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_id  = 2'(i);
            end
        end
    end
`endif

    // Sequencer: all outputs are registered and change together with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            gnt           <= '0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            active_id     <= 2'd0;
            arb_busy      <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
            rr_ptr        <= 2'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A busy serializer blocks arbitration entirely.
                    if (win_vld && !tx_busy) begin
                        state         <= ISSUE;
                        tx_p_data     <= req_data[int'(win_id)*WIDTH +: WIDTH];
                        active_id     <= win_id;
                        gnt           <= NREQ'(1) << win_id;
                        tx_data_valid <= 1'b1;
                        arb_busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Strobe and grant last exactly this one cycle.
                    state         <= WAIT_START;
                    gnt           <= '0;
                    tx_data_valid <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
                    rr_ptr        <= active_id;
`endif
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // Return to IDLE only; the next grant needs a fresh IDLE cycle.
                    if (!tx_busy) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    gnt           <= '0;
                    tx_data_valid <= 1'b0;
                    arb_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter (NREQ=4, WIDTH=8).
// Expected grants come from a ring-search model of the arbitration rule.
// The bench acts as the UART TX, driving tx_busy around each strobe.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  tx_busy;
    logic [NREQ-1:0]       gnt;
    logic                  tx_data_valid;
    logic [WIDTH-1:0]      tx_p_data;
    logic [1:0]            active_id;
    logic                  arb_busy;

    uart_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .tx_busy       (tx_busy),
        .gnt           (gnt),
        .tx_data_valid (tx_data_valid),
        .tx_p_data     (tx_p_data),
        .active_id     (active_id),
        .arb_busy      (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] id;
    } exp_t;

    exp_t       exp_q[$];
    int         checks  = 0;
    int         errors  = 0;
    int         strobes = 0;
    int         rr_ptr  = NREQ - 1;
    logic [7:0] last_data = 8'h00;

    logic [3:0]  pat;
    logic [3:0]  nxt;
    logic [31:0] dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Reference arbitration: search the ring starting after the last winner,
    // or simply take the lowest set bit when round robin is disabled.
    function automatic int pick(input logic [3:0] r);
`ifdef UART_TX_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic push_expect(input logic [3:0] r, input logic [31:0] d);
        exp_t e;
        int   w;
        w    = pick(r);
        e.g  = 4'b0001 << w;
        e.d  = d[w*8 +: 8];
        e.id = 2'(w);
        exp_q.push_back(e);
        last_data = e.d;
`ifdef UART_TX_ARB_RR_EN
        rr_ptr = w;
`endif
    endtask

    // Monitor: every strobe or grant must match the oldest expected transaction.
    always @(negedge clk) begin
        if (rst && (tx_data_valid || gnt != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {27'd0, tx_data_valid, gnt}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_valid", 32'(tx_data_valid), 32'd1);
                check("gnt", 32'(gnt), 32'(e.g));
                check("tx_p_data", 32'(tx_p_data), 32'(e.d));
                check("active_id", 32'(active_id), 32'(e.id));
                check("arb_busy_issue", 32'(arb_busy), 32'd1);
            end
            strobes++;
        end
    end

    // Wait for the next strobe; it must appear exactly lat cycles later.
    task automatic wait_strobe(input int lat, input string name);
        int start;
        int n;
        start = strobes;
        n = 0;
        while (strobes == start && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (strobes == start) check({name, "_timeout"}, 32'd0, 32'd1);
        else                  check({name, "_latency"}, 32'(n), 32'(lat));
    endtask

    // Play the UART: ws idle cycles before busy rises, then busy for len cycles.
    task automatic run_frame(input int ws, input int len, input bit junk);
        repeat (ws) begin
            @(negedge clk); #1;
            if (junk) begin req = 4'($urandom); req_data = $urandom; end
        end
        tx_busy = 1'b1;
        repeat (len) begin
            @(negedge clk); #1;
            if (junk) begin req = 4'($urandom); req_data = $urandom; end
        end
        check("busy_in_frame", 32'(arb_busy), 32'd1);
        check("data_hold", 32'(tx_p_data), 32'(last_data));
    endtask

    // Drop busy with a new request pattern; a nonzero pattern is granted two
    // cycles later (one cycle back to IDLE, one to arbitrate).
    task automatic end_frame(input logic [3:0] nr, input logic [31:0] nd);
        req      = nr;
        req_data = nd;
        tx_busy  = 1'b0;
        if (nr != 4'b0000) begin
            push_expect(nr, nd);
            wait_strobe(2, "spacing");
        end else begin
            repeat (3) begin @(negedge clk); #1; end
            check("idle_after_frame", 32'(arb_busy), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0; req = '0; tx_busy = 1'b0; rr_ptr = NREQ - 1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; req_data = '0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(tx_data_valid), 32'd0);
        check("rst_data", 32'(tx_p_data), 32'd0);
        check("rst_id", 32'(active_id), 32'd0);
        check("rst_busy", 32'(arb_busy), 32'd0);
        rst = 1'b1;

        // Single requester, then a 10-cycle frame.
        req = 4'b0001; req_data = 32'h0000_00A5;
        push_expect(req, req_data);
        wait_strobe(1, "first_grant");
        req = 4'b0000;
        run_frame(1, 10, 1'b0);
        end_frame(4'b0000, 32'd0);

        // Busy serializer at IDLE blocks arbitration.
        req = 4'b0100; req_data = 32'h00C3_0000; tx_busy = 1'b1;
        repeat (5) begin @(negedge clk); #1; end
        check("blocked_idle", 32'(arb_busy), 32'd0);
        tx_busy = 1'b0;
        push_expect(req, req_data);
        wait_strobe(1, "busy_release");
        req = 4'b0000;
        run_frame(0, 6, 1'b0);
        end_frame(4'b0000, 32'd0);

        // Reset asserted in WAIT_DONE clears outputs without a clock edge.
        req = 4'b1000; req_data = 32'h3C00_0000;
        push_expect(req, req_data);
        wait_strobe(1, "pre_reset");
        req = 4'b0000;
        @(negedge clk); #1 tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'd0);
        check("arst_valid", 32'(tx_data_valid), 32'd0);
        check("arst_data", 32'(tx_p_data), 32'd0);
        check("arst_id", 32'(active_id), 32'd0);
        check("arst_busy", 32'(arb_busy), 32'd0);
        tx_busy = 1'b0; rr_ptr = NREQ - 1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        req = 4'b0010; req_data = 32'h0000_5A00;
        push_expect(req, req_data);
        wait_strobe(1, "post_reset");
        req = 4'b0000;
        run_frame(2, 4, 1'b0);
        end_frame(4'b0000, 32'd0);

        // All four requesting, held over four frames.
        do_reset();
        req = 4'b1111; req_data = 32'h4433_2211;
        push_expect(req, req_data);
        wait_strobe(1, "all_req");
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 10, 1'b0);
            end_frame(4'b1111, 32'h4433_2211);
        end
        run_frame(1, 10, 1'b0);
        end_frame(4'b0000, 32'd0);

        // Randomized traffic with ignored request churn during frames.
        for (int t = 0; t < 30; t++) begin
            pat = 4'($urandom_range(1, 15));
            dat = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                tx_busy = 1'b1; req = 4'($urandom); req_data = $urandom;
                repeat ($urandom_range(1, 4)) begin @(negedge clk); #1; end
            end
            req = pat; req_data = dat; tx_busy = 1'b0;
            push_expect(pat, dat);
            wait_strobe(1, "rand_latency");
            for (int c = 0; c < 6; c++) begin
                run_frame($urandom_range(0, 3), $urandom_range(2, 12), 1'($urandom_range(0, 1)));
                if (c == 5 || $urandom_range(0, 3) == 0) nxt = 4'b0000;
                else                                    nxt = 4'($urandom_range(1, 15));
                end_frame(nxt, $urandom);
                if (nxt == 4'b0000) break;
            end
        end

        repeat (5) @(negedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
